// File: rtl/pic_stream.sv
// pic_stream: streams one image from a synchronous ROM over valid/ready with row/frame markers
module pic_stream #(
  parameter int DATA_W  = 16,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int NUM_IMG = 1,
  parameter int ADDR_W  = 10,
  parameter int SEL_W   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  img_sel,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);
  localparam int PIX   = IMG_W * IMG_H;
  localparam int DEPTH = ROM_LAT + 2;
  localparam int CW    = $clog2(PIX + 1);
  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int NW    = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2;
  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     rd_cnt;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic [ROM_LAT-1:0] pipe;
  logic [NW-1:0]     inflight, count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, push, pop, last_rd;
  assign accept    = state == IDLE && start && 32'(img_sel) < NUM_IMG;
  // credit check: every issued read is guaranteed a FIFO slot when it returns
  assign rom_en    = state == FETCH && (32'(inflight) + 32'(count) < DEPTH);
  assign rom_addr  = base + ADDR_W'(rd_cnt);
  assign last_rd   = rd_cnt == CW'(PIX - 1);
  assign push      = pipe[ROM_LAT-1];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_eol   = out_valid && col == XW'(IMG_W - 1);
  assign out_eof   = out_eol && row == YW'(IMG_H - 1);
  assign busy      = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rom_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      rd_cnt   <= '0;
      col      <= '0;
      row      <= '0;
      pipe     <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      done     <= state == DRAIN && pop && out_eof;
      sel_err  <= state == IDLE && start && 32'(img_sel) >= NUM_IMG;
      pipe[0]  <= rom_en;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
      inflight <= inflight + NW'(rom_en) - NW'(push);
      count    <= count + NW'(push) - NW'(pop);
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        col    <= out_eol ? '0 : col + 1'b1;
        if (out_eol) row <= out_eof ? '0 : row + 1'b1;
      end
      if (rom_en) rd_cnt <= rd_cnt + 1'b1;
      if (accept) begin
        state  <= FETCH;
        base   <= ADDR_W'(32'(img_sel) * PIX);
        rd_cnt <= '0;
        col    <= '0;
        row    <= '0;
      end else if (state == FETCH && rom_en && last_rd) state <= DRAIN;
      else if (state == DRAIN && pop && out_eof) state <= IDLE;
    end
endmodule

// File: tb/tb_pic_stream.sv
// tb_pic_stream: randomized scoreboard bench for pic_stream against a pixel-list reference model
module tb_pic_stream;
  localparam int DATA_W = 16, IMG_W = 28, IMG_H = 28, NUM_IMG = 4, ADDR_W = 12, SEL_W = 4, LAT = 3;
  localparam int PIX = IMG_W * IMG_H;
  typedef struct packed {logic [DATA_W-1:0] d; logic eol; logic eof;} pix_t;
  logic clk = 0, rst = 1, start = 0, out_ready = 0, rand_ready = 0;
  logic [SEL_W-1:0] img_sel = '0;
  logic rom_en, out_valid, out_eol, out_eof, busy, done, sel_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, out_data;
  logic [DATA_W-1:0] rq [LAT];
  pix_t exp_q[$];
  pix_t e, held;
  logic stalled = 0;
  int total = 0, bad = 0, cyc = 0, t0 = 0, t_first = -1, t_done = -1, t_sel = -1, n_done = 0, n_sel = 0, addr_left = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  pic_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMG(NUM_IMG), .ADDR_W(ADDR_W),
               .SEL_W(SEL_W), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .img_sel(img_sel), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done), .sel_err(sel_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM holds address+1, delivered LAT cycles after the read
  always @(posedge clk) begin
    rq[0] <= DATA_W'(rom_addr) + 1'b1;
    for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_data = rq[LAT-1];

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_hold", 32'({out_data, out_eol, out_eof}), 32'(held));
      end
      stalled = out_valid && !out_ready;
      held = {out_data, out_eol, out_eof};
      if (out_valid && t_first < 0) t_first = cyc;
      if (out_valid && out_ready) begin
        chk("pixel_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pixel", 32'({out_data, out_eol, out_eof}), 32'(e));
        end
      end
      if (rom_en) begin
        chk("read_expected", 32'(addr_left != 0), 1);
        if (addr_left != 0) begin
          chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
          exp_addr++;
          addr_left--;
        end
      end
      if (done) begin
        n_done++;
        t_done = cyc;
        chk("busy_at_done", 32'(busy), 0);
      end
      if (sel_err) begin
        n_sel++;
        t_sel = cyc;
      end
    end

  task automatic do_start(input int k);
    t_first = -1; n_done = 0; n_sel = 0;
    if (k < NUM_IMG) begin
      for (int i = 0; i < PIX; i++)
        exp_q.push_back({DATA_W'(k * PIX + i + 1), i % IMG_W == IMG_W - 1, i == PIX - 1});
      exp_addr = ADDR_W'(k * PIX);
      addr_left = PIX;
    end
    @(posedge clk); #1 start = 1; img_sel = SEL_W'(k);
    @(posedge clk); #1 start = 0; t0 = cyc;
  endtask

  task automatic wait_left(input int n);
    for (int i = 0; i < 8000 && exp_q.size() > n; i++) @(posedge clk);
    chk("reach_pixel", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 8000 && n_done == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("done_once", 32'(n_done), 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("reads_all", 32'(addr_left), 0);
  endtask

  task automatic reset_check();
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_flags", 32'({rom_en, out_valid, out_eol, out_eof, busy, done, sel_err}), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_check();
    rst = 0;
    do_start(0);
    @(negedge clk) chk("busy_cycle1", 32'(busy), 1);
    finish_frame();
    chk("first_valid_cycle", 32'(t_first), 32'(t0 + 1 + LAT));
    chk("done_cycle", 32'(t_done), 32'(t0 + LAT + 1 + PIX));
    rand_ready = 1;
    do_start(2);
    finish_frame();
    do_start(4);
    repeat (6) @(posedge clk);
    chk("sel_err_count", 32'(n_sel), 1);
    chk("sel_err_cycle", 32'(t_sel), 32'(t0));
    chk("sel_busy", 32'(busy), 0);
    rand_ready = 0;
    do_start(1);
    wait_left(PIX - 100);
    #1 start = 1; img_sel = 3;
    @(posedge clk); #1 img_sel = 7;
    @(posedge clk); #1 start = 0;
    finish_frame();
    chk("ignored_start_no_sel_err", 32'(n_sel), 0);
    rand_ready = 1;
    do_start(3);
    wait_left(PIX - 300);
    #2 rst = 1;
    exp_q.delete();
    addr_left = 0;
    n_done = 0;
    #1 reset_check();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (30) @(posedge clk);
    chk("no_done_after_rst", 32'(n_done), 0);
    chk("no_valid_after_rst", 32'(out_valid), 0);
    do_start(0);
    finish_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
